// File: rtl/gcttt_pkg.sv
// Shared types and defaults for the grid coordinate queue.
package gcttt_pkg;

    localparam int COORD_W_DEF    = 4;
    localparam int GRID_CELLS_DEF = 9;

    typedef logic [COORD_W_DEF-1:0] coord_t;

    // Interrupt handshake state
    // IDLE    | queue empty, no request raised
    // PENDING | entry waiting, ipu_int asserted
    // ACKED   | head popped, waiting for int_ack to fall
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACKED   = 2'd2
    } gq_state_e;

endpackage

// File: rtl/coord_sync_fifo.sv
// Synchronous FIFO with head/tail peek and a look-ahead of the next head.
module coord_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail,
    output logic [WIDTH-1:0] head_nxt,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_nxt,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    tail_ptr;

    // Pointer advance with explicit wrap (DEPTH need not be a power of two) and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        tail_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - 1'b1;
        // the slot being written this cycle is not in mem_q yet, so bypass it
        head_nxt = (push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until pointed at by count
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head      = mem_q[rd_ptr_q];
    assign tail      = mem_q[tail_ptr];
    assign count     = count_q;
    assign count_nxt = count_d;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/grid_coord_queue.sv
// Coordinate queue between IPU and proc: write filters, interrupt handshake, sticky errors.
//
// state   | meaning
// IDLE    | nothing pending, ipu_int low
// PENDING | head valid, ipu_int high, next int_ack pops
// ACKED   | pop done, ignore int_ack until it falls
module grid_coord_queue
    import gcttt_pkg::*;
#(
    parameter int COORD_W    = COORD_W_DEF,
    parameter int DEPTH      = 4,
    parameter int GRID_CELLS = GRID_CELLS_DEF,
    parameter int DUP_FILTER = 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic [COORD_W-1:0] coord_in,
    input  logic               int_ack,
    input  logic               clr_err,
    output logic               ipu_int,
    output logic [COORD_W-1:0] grid_coord,
    output logic [CW-1:0]      count,
    output logic               overflow,
    output logic               bad_coord
);

    gq_state_e          state_q, state_d;
    logic               ipu_int_q, ipu_int_d;
    logic [COORD_W-1:0] grid_coord_q, grid_coord_d;
    logic               overflow_q, overflow_d;
    logic               bad_coord_q, bad_coord_d;

    logic               in_range, is_dup, wr_ok, push, pop;
    logic [COORD_W-1:0] fifo_head, fifo_tail, fifo_head_nxt;
    logic [CW-1:0]      fifo_count, fifo_count_nxt;
    logic               fifo_full, fifo_empty;

    coord_sync_fifo #(
        .WIDTH (COORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (coord_in),
        .head      (fifo_head),
        .tail      (fifo_tail),
        .head_nxt  (fifo_head_nxt),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write filtering; the dup compare uses the tail as it stands before any same-cycle pop
    always_comb begin
        in_range = int'(coord_in) < GRID_CELLS;
        is_dup   = (DUP_FILTER != 0) && !fifo_empty && (coord_in == fifo_tail);
        pop      = (state_q == ST_PENDING) && int_ack;
        wr_ok    = write_en && in_range && !is_dup;
        push     = wr_ok && (!fifo_full || pop);
    end

    // Sticky flags: a same-cycle set beats clr_err
    always_comb begin
        overflow_d  = (wr_ok && fifo_full && !pop) || (overflow_q && !clr_err);
        bad_coord_d = (write_en && !in_range) || (bad_coord_q && !clr_err);
    end

    // Next head shown on grid_coord; holds the last value once the queue drains
    always_comb begin
        grid_coord_d = grid_coord_q;
        if (pop) begin
            if (fifo_count_nxt != '0) grid_coord_d = fifo_head_nxt;
        end else if (fifo_empty) begin
            if (push) grid_coord_d = coord_in;
        end else begin
            grid_coord_d = fifo_head;
        end
    end

    // Interrupt handshake next state; ipu_int is a registered decode of it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (fifo_count_nxt != '0) state_d = ST_PENDING;
            ST_PENDING: if (int_ack) state_d = ST_ACKED;
            ST_ACKED:   if (!int_ack) state_d = (fifo_count_nxt != '0) ? ST_PENDING : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        ipu_int_d = (state_d == ST_PENDING);
    end

    // Control registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ipu_int_q    <= 1'b0;
            grid_coord_q <= '0;
            overflow_q   <= 1'b0;
            bad_coord_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ipu_int_q    <= ipu_int_d;
            grid_coord_q <= grid_coord_d;
            overflow_q   <= overflow_d;
            bad_coord_q  <= bad_coord_d;
        end
    end

    assign ipu_int    = ipu_int_q;
    assign grid_coord = grid_coord_q;
    assign count      = fifo_count;
    assign overflow   = overflow_q;
    assign bad_coord  = bad_coord_q;

endmodule

// File: tb/tb_grid_coord_queue.sv
// Bench for grid_coord_queue: directed scenarios plus randomized traffic against a queue model.
module tb_grid_coord_queue;

    logic       clk = 1'b0;
    logic       rst, write_en, int_ack, clr_err;
    logic [3:0] coord_in;
    logic       ipu_int, overflow, bad_coord;
    logic [3:0] grid_coord;
    logic [2:0] count;

    logic       nd_rst, nd_we, nd_ack, nd_clr;
    logic [3:0] nd_coord;
    logic       nd_ipu, nd_ovf, nd_bad;
    logic [3:0] nd_grid;
    logic [2:0] nd_count;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int mq[$];
    bit m_ipu, m_hold, m_ovf, m_bad;
    int m_grid;

    always #5 clk = ~clk;

    grid_coord_queue #(.COORD_W(4), .DEPTH(4), .GRID_CELLS(9), .DUP_FILTER(1)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .coord_in(coord_in),
        .int_ack(int_ack), .clr_err(clr_err), .ipu_int(ipu_int),
        .grid_coord(grid_coord), .count(count), .overflow(overflow), .bad_coord(bad_coord)
    );

    grid_coord_queue #(.COORD_W(4), .DEPTH(4), .GRID_CELLS(9), .DUP_FILTER(0)) dut_nd (
        .clk(clk), .rst(nd_rst), .write_en(nd_we), .coord_in(nd_coord),
        .int_ack(nd_ack), .clr_err(nd_clr), .ipu_int(nd_ipu),
        .grid_coord(nd_grid), .count(nd_count), .overflow(nd_ovf), .bad_coord(nd_bad)
    );

    // Drive one cycle on the main DUT and advance the model with the same inputs.
    task automatic cyc(input bit r, input bit we, input int c, input bit ak, input bit clr);
        bit pop, wr_ok, push, dup;
        rst = r; write_en = we; coord_in = 4'(c); int_ack = ak; clr_err = clr;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_ipu = 0; m_hold = 0; m_ovf = 0; m_bad = 0; m_grid = 0;
        end else begin
            pop   = m_ipu && ak;
            dup   = (mq.size() > 0) && (c == mq[$]);
            wr_ok = we && (c < 9) && !dup;
            push  = wr_ok && ((mq.size() < 4) || pop);
            m_bad = (m_bad && !clr) || (we && c >= 9);
            m_ovf = (m_ovf && !clr) || (wr_ok && !push);
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(c);
            if (pop) begin
                m_ipu = 0; m_hold = 1;
            end else if (m_hold && ak) begin
                m_ipu = 0;
            end else begin
                m_hold = 0; m_ipu = (mq.size() > 0);
            end
            if (mq.size() > 0) m_grid = mq[0];
        end
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        n_checks++;
        if ({ipu_int, grid_coord, count, overflow, bad_coord} !== 10'b0)
            $display("FAIL reset_outputs: got %b, want %b", {ipu_int, grid_coord, count, overflow, bad_coord}, 10'b0);
        else n_pass++;
    endtask

    task automatic test_basic;
        cyc(0, 1, 2, 0, 0);
        n_checks++;
        if ({ipu_int, grid_coord, count} !== {1'b1, 4'd2, 3'd1})
            $display("FAIL basic_write: ipu=%0d grid=%0d count=%0d, want 1 2 1", ipu_int, grid_coord, count);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_checks++;
            if ({ipu_int, count} !== {1'b0, 3'd0})
                $display("FAIL basic_held_ack%0d: ipu=%0d count=%0d, want 0 0", i, ipu_int, count);
            else n_pass++;
        end
        cyc(0, 0, 0, 0, 0);
        n_checks++;
        if ({ipu_int, count, grid_coord} !== {1'b0, 3'd0, 4'd2})
            $display("FAIL basic_release: ipu=%0d count=%0d grid=%0d, want 0 0 2", ipu_int, count, grid_coord);
        else n_pass++;
    endtask

    task automatic test_sequence;
        int exp_seq[3] = '{1, 5, 7};
        foreach (exp_seq[i]) cyc(0, 1, exp_seq[i], 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({ipu_int, grid_coord} !== {1'b1, 4'(exp_seq[i])})
                $display("FAIL seq_head%0d: ipu=%0d grid=%0d, want 1 %0d", i, ipu_int, grid_coord, exp_seq[i]);
            else n_pass++;
            cyc(0, 0, 0, 1, 0);
            n_checks++;
            if ({ipu_int, count} !== {1'b0, 3'(2 - i)})
                $display("FAIL seq_ack%0d: ipu=%0d count=%0d, want 0 %0d", i, ipu_int, count, 2 - i);
            else n_pass++;
            cyc(0, 0, 0, 0, 0);
            n_checks++;
            if (ipu_int !== (i < 2))
                $display("FAIL seq_rerise%0d: ipu=%0d, want %0d", i, ipu_int, (i < 2));
            else n_pass++;
            cyc(0, 0, 0, 0, 0);
        end
        n_checks++;
        if ({ipu_int, grid_coord, count} !== {1'b0, 4'd7, 3'd0})
            $display("FAIL seq_drained: ipu=%0d grid=%0d count=%0d, want 0 7 0", ipu_int, grid_coord, count);
        else n_pass++;
    endtask

    task automatic test_overflow;
        for (int k = 0; k < 5; k++) cyc(0, 1, k, 0, 0);
        n_checks++;
        if ({count, overflow} !== {3'd4, 1'b1})
            $display("FAIL ovf_set: count=%0d overflow=%0d, want 4 1", count, overflow);
        else n_pass++;
        cyc(0, 0, 0, 0, 1);
        n_checks++;
        if ({overflow, count} !== {1'b0, 3'd4})
            $display("FAIL ovf_clear: overflow=%0d count=%0d, want 0 4", overflow, count);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (grid_coord !== 4'(k))
                $display("FAIL ovf_drain%0d: grid=%0d, want %0d", k, grid_coord, k);
            else n_pass++;
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        n_checks++;
        if ({count, grid_coord, ipu_int} !== {3'd0, 4'd3, 1'b0})
            $display("FAIL ovf_no_4: count=%0d grid=%0d ipu=%0d, want 0 3 0", count, grid_coord, ipu_int);
        else n_pass++;
    endtask

    task automatic test_full_pushpop;
        int exp_seq[4] = '{1, 2, 3, 8};
        for (int k = 0; k < 4; k++) cyc(0, 1, k, 0, 0);
        cyc(0, 1, 8, 1, 0);
        n_checks++;
        if ({count, overflow, grid_coord} !== {3'd4, 1'b0, 4'd1})
            $display("FAIL full_pushpop: count=%0d overflow=%0d grid=%0d, want 4 0 1", count, overflow, grid_coord);
        else n_pass++;
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (grid_coord !== 4'(exp_seq[k]))
                $display("FAIL full_drain%0d: grid=%0d, want %0d", k, grid_coord, exp_seq[k]);
            else n_pass++;
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        n_checks++;
        if (count !== 3'd0)
            $display("FAIL full_empty: count=%0d, want 0", count);
        else n_pass++;
    endtask

    task automatic test_bad_dup;
        cyc(0, 1, 9, 0, 0);
        n_checks++;
        if ({bad_coord, count, ipu_int} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL bad_set: bad=%0d count=%0d ipu=%0d, want 1 0 0", bad_coord, count, ipu_int);
        else n_pass++;
        cyc(0, 0, 0, 0, 1);
        n_checks++;
        if (bad_coord !== 1'b0)
            $display("FAIL bad_clear: bad=%0d, want 0", bad_coord);
        else n_pass++;
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 3, 0, 0);
        n_checks++;
        if ({count, overflow, bad_coord} !== {3'd1, 1'b0, 1'b0})
            $display("FAIL dup_drop: count=%0d ovf=%0d bad=%0d, want 1 0 0", count, overflow, bad_coord);
        else n_pass++;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        nd_we = 1; nd_coord = 4'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nd_we = 0;
        n_checks++;
        if ({nd_count, nd_grid, nd_ipu} !== {3'd2, 4'd3, 1'b1})
            $display("FAIL nodup_accept: count=%0d grid=%0d ipu=%0d, want 2 3 1", nd_count, nd_grid, nd_ipu);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 2, 0, 0);
        cyc(0, 1, 3, 0, 0);
        n_checks++;
        if ({ipu_int, count} !== {1'b1, 3'd3})
            $display("FAIL rmid_pre: ipu=%0d count=%0d, want 1 3", ipu_int, count);
        else n_pass++;
        cyc(1, 1, 4, 1, 0);
        n_checks++;
        if ({ipu_int, grid_coord, count, overflow, bad_coord} !== 10'b0)
            $display("FAIL rmid_zero: got %b, want %b", {ipu_int, grid_coord, count, overflow, bad_coord}, 10'b0);
        else n_pass++;
        cyc(0, 1, 6, 0, 0);
        n_checks++;
        if ({ipu_int, grid_coord, count} !== {1'b1, 4'd6, 3'd1})
            $display("FAIL rmid_fresh: ipu=%0d grid=%0d count=%0d, want 1 6 1", ipu_int, grid_coord, count);
        else n_pass++;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        int c;
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, 12);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), c,
                ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
            n_checks++;
            if ({ipu_int, grid_coord, count, overflow, bad_coord} !==
                {m_ipu, 4'(m_grid), 3'(mq.size()), m_ovf, m_bad})
                $display("FAIL random_cyc%0d: ipu/grid/count/ovf/bad got %0d %0d %0d %0d %0d, want %0d %0d %0d %0d %0d",
                         i, ipu_int, grid_coord, count, overflow, bad_coord,
                         m_ipu, m_grid, mq.size(), m_ovf, m_bad);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1; write_en = 0; coord_in = '0; int_ack = 0; clr_err = 0;
        nd_rst = 1; nd_we = 0; nd_coord = '0; nd_ack = 0; nd_clr = 0;
        test_reset;
        nd_rst = 0;
        test_basic;
        test_sequence;
        test_overflow;
        test_full_pushpop;
        test_bad_dup;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
